// File: rtl/visu_mon_writer.sv
// Debug-record producer: watches 64 probes and writes one record per changed probe to the LED monitor.
// Scans the change bitmap round-robin, spaces writes apart, and periodically re-sends every slot.
module visu_mon_writer #(
  parameter int unsigned HOLD_CYCLES    = 3,
  parameter int unsigned REFRESH_PERIOD = 25_000_000,
  parameter logic [11:0] ON_COLOR       = 12'h0F0,
  parameter logic [11:0] OFF_COLOR      = 12'h200
) (
  input  logic        i_clk25Mhz,
  input  logic        i_reset,
  input  logic [63:0] i_probe,
  output logic        o_cs,
  output logic [18:0] o_debugInfo,
  output logic        o_busy,
  output logic        o_led
);

  localparam int unsigned NSLOT = 64;
  localparam int unsigned PW    = 6;
  localparam int unsigned RECW  = 19;
  localparam int unsigned GW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned RW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, GAP} state_e;

  state_e             state_q, state_d;
  logic [NSLOT-1:0]   pending_q, pending_d;
  logic [NSLOT-1:0]   r_probe_q, r_probe_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      slot_q, slot_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [RW-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic               cs_q, cs_d;
  logic [RECW-1:0]    info_q, info_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
  logic               refresh_wrap;
  logic [NSLOT-1:0]   set_mask, clr_mask;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    slot_d        = slot_q;
    gap_d         = gap_q;
    cs_d          = 1'b1;
    info_d        = info_q;
    led_d         = led_q;
    r_probe_d     = i_probe;
    clr_mask      = '0;
    refresh_cnt_d = refresh_cnt_q;
    refresh_wrap  = 1'b0;

    if (REFRESH_PERIOD != 0) begin
      refresh_wrap  = (refresh_cnt_q == RW'(REFRESH_PERIOD - 1));
      refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);
    end
    if (refresh_wrap) begin
      led_d = ~led_q;
    end
    set_mask = (i_probe ^ r_probe_q) | {NSLOT{refresh_wrap}};

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Record value is the one r_probe will hold during the EMIT cycle.
        if (pending_q[ptr_q]) begin
          slot_d  = ptr_q;
          state_d = EMIT;
          cs_d    = 1'b0;
          info_d  = {ptr_q, i_probe[ptr_q], i_probe[ptr_q] ? ON_COLOR : OFF_COLOR};
        end else if (pending_q == '0) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      EMIT: begin
        clr_mask = NSLOT'(1) << slot_q;
        ptr_d    = slot_q + PW'(1);
        gap_d    = GW'(HOLD_CYCLES);
        state_d  = (HOLD_CYCLES == 0) ? SCAN : GAP;
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new change or refresh overrides the clear of the slot just written.
    pending_d = (pending_q & ~clr_mask) | set_mask;
    busy_d    = |pending_d;
  end

  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset) begin
      state_q       <= IDLE;
      pending_q     <= '1;
      r_probe_q     <= '0;
      ptr_q         <= '0;
      slot_q        <= '0;
      gap_q         <= '0;
      refresh_cnt_q <= '0;
      cs_q          <= 1'b1;
      info_q        <= '0;
      busy_q        <= 1'b1;
      led_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      r_probe_q     <= r_probe_d;
      ptr_q         <= ptr_d;
      slot_q        <= slot_d;
      gap_q         <= gap_d;
      refresh_cnt_q <= refresh_cnt_d;
      cs_q          <= cs_d;
      info_q        <= info_d;
      busy_q        <= busy_d;
      led_q         <= led_d;
    end
  end

  assign o_cs        = cs_q;
  assign o_debugInfo = info_q;
  assign o_busy      = busy_q;
  assign o_led       = led_q;

endmodule

// File: tb/tb_visu_mon_writer.sv
// Scoreboard bench for visu_mon_writer: expected records (slot, value, cycle) are queued by the
// stimulus from a cyclic-order/timing model; monitors pop and compare on every write strobe.
module tb_visu_mon_writer;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [63:0] probe, probe2;
  logic        cs, cs2, busy, busy2, led, led2;
  logic [18:0] info, info2;

  always #5 clk = ~clk;

  visu_mon_writer #(.HOLD_CYCLES(HOLD), .REFRESH_PERIOD(0)) dut1 (
    .i_clk25Mhz(clk), .i_reset(rst_n), .i_probe(probe),
    .o_cs(cs), .o_debugInfo(info), .o_busy(busy), .o_led(led));

  visu_mon_writer #(.HOLD_CYCLES(0), .REFRESH_PERIOD(200)) dut2 (
    .i_clk25Mhz(clk), .i_reset(rst2_n), .i_probe(probe2),
    .o_cs(cs2), .o_debugInfo(info2), .o_busy(busy2), .o_led(led2));

  typedef struct {
    int slot;
    bit val;
    int cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mptr = 0;
  int   r2_base = 0;
  bit   r2_on = 1'b0;
  bit   r2_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] rec(input int slot, input bit v);
    rec = {6'(slot), v, (v ? 12'h0F0 : 12'h200)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Write-strobe monitor for the primary instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cs === 1'b0) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write1 actual=%0h required=none at cycle %0d", info, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("record1", 64'(info), 64'(rec(e.slot, e.val)));
        check("write_cycle1", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Monitor for the refresh instance: records plus heartbeat phase.
  always @(negedge clk) begin
    if (r2_on && rst2_n === 1'b1) begin
      check("led2", 64'(led2), 64'(((cyc - r2_base) / 200) % 2));
      if (cs2 === 1'b0) begin
        if (q2.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write2 actual=%0h required=none at cycle %0d", info2, cyc);
        end else begin
          exp_t e;
          e = q2.pop_front();
          check("record2", 64'(info2), 64'(rec(e.slot, e.val)));
          check("write_cycle2", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Full sweep after reset release at the negedge with cycle count c.
  task automatic push_sweep(input int c);
    for (int i = 0; i < 64; i++) begin
      q1.push_back('{i, bit'(probe[i]), c + 2 + i * (HOLD + 2)});
    end
    mptr = 0;
  endtask

  // Drive a new probe value from idle; expected writes follow cyclic order from the pointer.
  task automatic apply(input logic [63:0] nv);
    logic [63:0] m;
    int c, k, last;
    c    = cyc;
    m    = probe ^ nv;
    probe = nv;
    k    = 0;
    last = 0;
    for (int i = 0; i < 64; i++) begin
      int s;
      s = (mptr + i) % 64;
      if (m[s]) begin
        q1.push_back('{s, bit'(nv[s]), c + 3 + i + k * (HOLD + 1)});
        k++;
        last = s;
      end
    end
    if (k > 0) mptr = (last + 1) % 64;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q1.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, q1.size());
      q1.delete();
    end
    repeat (HOLD + 4) @(negedge clk);
    check({name, "_busy_idle"}, 64'(busy), 64'(0));
  endtask

  // Refresh instance: held in reset once four sweeps have completed.
  initial begin
    wait (r2_on);
    repeat (750) @(negedge clk);
    r2_on  = 1'b0;
    rst2_n = 1'b0;
    r2_done = 1'b1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] nv;
    int c, w;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    probe  = '0;
    probe2 = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("reset_cs", 64'(cs), 64'(1));
    check("reset_info", 64'(info), 64'(0));
    check("reset_led", 64'(led), 64'(0));
    check("reset_busy", 64'(busy), 64'(1));

    // Release both instances together.
    @(negedge clk);
    c = cyc;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    push_sweep(c);
    r2_base = c;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) begin
        q2.push_back('{i, bit'(probe2[i]), c + 200 * r + 2 + 2 * i});
      end
    end
    r2_on = 1'b1;
    wait_drain("sweep");

    // Single bit 0 change with pointer at 0.
    apply(probe | 64'h1);
    wait_drain("bit0");

    // Move pointer to 10, then change bits 5 and 60 together.
    apply(probe ^ (64'h1 << 9));
    wait_drain("bit9");
    apply(probe | (64'h1 << 5) | (64'h1 << 60));
    wait_drain("wrap");

    // Toggle bit 7 again in the very cycle it is being written.
    c = cyc;
    probe[7] = ~probe[7];
    w = c + 3 + ((7 - mptr + 64) % 64);
    q1.push_back('{7, bit'(probe[7]), w});
    repeat (w - c) @(negedge clk);
    probe[7] = ~probe[7];
    q1.push_back('{7, bit'(probe[7]), w + HOLD + 2 + 63});
    mptr = 8;
    wait_drain("emit_collision");

    // Random multi-bit changes from idle.
    for (int it = 0; it < 12; it++) begin
      nv = probe;
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        nv[$urandom_range(0, 63)] ^= 1'b1;
      end
      apply(nv);
      wait_drain("random");
    end

    // Reset during the gap after the slot-20 write of a fresh sweep.
    rst_n = 1'b0;
    @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    push_sweep(c);
    while (cyc < c + 2 + 20 * (HOLD + 2) + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_cs", 64'(cs), 64'(1));
    check("midreset_info", 64'(info), 64'(0));
    check("midreset_busy", 64'(busy), 64'(1));
    q1.delete();
    repeat (3) @(negedge clk);
    c = cyc;
    rst_n = 1'b1;
    push_sweep(c);
    wait_drain("resweep");

    begin
      int n;
      n = 0;
      while (!r2_done && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    check("r2_finished", 64'(r2_done), 64'(1));
    check("q2_empty", 64'(q2.size()), 64'(0));
    check("q1_empty", 64'(q1.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
